// File: rtl/speech_pkg.sv
// Shared speech front-end definitions: sample width and type, frame-scheduler
// states and the default frame geometry used by the feature extractor.
package speech_pkg;

  localparam int DATA_W        = 16;
  localparam int FRAME_LEN_DEF = 256;
  localparam int HOP_DEF       = 128;

  typedef logic signed [DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    ADVANCE
  } sched_state_e;

endpackage

// File: rtl/frame_ring_buffer.sv
// Simple dual-port sample RAM: one write port and one registered read port
// with single-cycle latency, written so it maps onto block RAM.
module frame_ring_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // The read register only moves on a read, so it holds the sample under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/audio_frame_scheduler.sv
// Buffers the audio sample stream and emits overlapping FRAME_LEN frames every HOP samples.
// Define AUDIO_FRAME_DROP_EN to drop (and count) samples instead of backpressuring the source.
module audio_frame_scheduler #(
  parameter int DATA_W    = speech_pkg::DATA_W,
  parameter int FRAME_LEN = speech_pkg::FRAME_LEN_DEF,
  parameter int HOP       = speech_pkg::HOP_DEF,
  parameter int ADDR_W    = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     out_ready,
  output logic                     out_first,
  output logic                     out_last,
  output logic [15:0]              frame_idx,
  output logic [15:0]              drop_cnt
);
  import speech_pkg::*;

  localparam logic [ADDR_W:0]   DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   FRAME_C = (ADDR_W+1)'(FRAME_LEN);
  localparam logic [ADDR_W:0]   HOP_C   = (ADDR_W+1)'(HOP);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(FRAME_LEN - 1);

  sched_state_e      state_q;
  logic [ADDR_W:0]   wr_ptr_q;
  logic [ADDR_W:0]   fs_ptr_q;
  logic [ADDR_W-1:0] rd_cnt_q;
  logic              out_valid_q;
  logic              out_first_q;
  logic              out_last_q;
  logic [15:0]       frame_idx_q;
  logic [ADDR_W:0]   fill;
  logic              space;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  // The extra pointer bit distinguishes a full buffer from an empty one.
  assign fill    = wr_ptr_q - fs_ptr_q;
  assign space   = (fill < DEPTH_C);
  assign wr_en   = in_valid && space;
  assign rd_en   = (state_q == STREAM) && (!out_valid_q || out_ready);
  assign rd_addr = fs_ptr_q[ADDR_W-1:0] + rd_cnt_q;

`ifdef AUDIO_FRAME_DROP_EN
  logic [15:0] drop_cnt_q;

  assign in_ready = 1'b1;
  assign drop_cnt = drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (in_valid && !space && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end
`else
  assign in_ready = space;
  assign drop_cnt = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
    end else if (wr_en) begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
    end
  end

  frame_ring_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i (in_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Frame sequencing; fs_ptr only moves once the last sample has been handed off.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fs_ptr_q    <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_idx_q <= '0;
    end else begin
      if (rd_en) begin
        out_valid_q <= 1'b1;
        out_first_q <= (rd_cnt_q == '0);
        out_last_q  <= (rd_cnt_q == LAST_C);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        out_first_q <= 1'b0;
        out_last_q  <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= FILL;
          end
        end
        FILL: begin
          if (!enable) begin
            state_q <= IDLE;
          end else if (fill >= FRAME_C) begin
            state_q  <= STREAM;
            rd_cnt_q <= '0;
          end
        end
        STREAM: begin
          if (rd_en) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
            if (rd_cnt_q == LAST_C) begin
              state_q <= ADVANCE;
            end
          end
        end
        ADVANCE: begin
          if (out_valid_q && out_ready && out_last_q) begin
            fs_ptr_q    <= fs_ptr_q + HOP_C;
            frame_idx_q <= frame_idx_q + 16'd1;
            state_q     <= enable ? FILL : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = rd_data;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign frame_idx = frame_idx_q;

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Scoreboard bench for audio_frame_scheduler with FRAME_LEN=8, HOP=4, ADDR_W=4.
// Directed scenarios push expected frames; a negedge monitor checks every presented sample.
module tb_audio_frame_scheduler;

  localparam int FL = 8;
  localparam int HP = 4;
  localparam int AW = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               in_ready;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               out_ready;
  logic               out_first;
  logic               out_last;
  logic [15:0]        frame_idx;
  logic [15:0]        drop_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int accepted    = 0;

  typedef struct {
    logic [15:0] data;
    logic        first;
    logic        last;
    logic [15:0] idx;
  } exp_t;

  exp_t expQ[$];

  always #5 clk = ~clk;

  audio_frame_scheduler #(
    .DATA_W    (16),
    .FRAME_LEN (FL),
    .HOP       (HP),
    .ADDR_W    (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_first (out_first),
    .out_last  (out_last),
    .frame_idx (frame_idx),
    .drop_cnt  (drop_cnt)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushFrame(input int start, input int idx);
    for (int k = 0; k < FL; k++) begin
      exp_t e;
      e.data  = 16'(start + k);
      e.first = (k == 0);
      e.last  = (k == FL - 1);
      e.idx   = 16'(idx);
      expQ.push_back(e);
    end
  endtask

  // Feeds a ramp starting at 'start', holding each sample until it is accepted.
  task automatic applyStimulus(input int start, input int count);
    for (int i = 0; i < count; i++) begin
      int   waitCyc;
      logic took;
      waitCyc  = 0;
      took     = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'(start + i);
      while (!took) begin
        @(negedge clk);
        took = in_ready;
        @(posedge clk);
        #1;
        if (!took) begin
          waitCyc++;
          if (waitCyc > 300) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL in_ready_timeout: sample %0d never accepted, required acceptance", start + i);
            in_valid = 1'b0;
            return;
          end
        end
      end
      accepted++;
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget, input string name);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput({"drain_", name}, 64'(expQ.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic waitFrameStart(input int idx, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(out_valid && out_first && frame_idx == 16'(idx)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({"start_", name}, {out_valid, out_first, frame_idx}, {1'b1, 1'b1, 16'(idx)});
  endtask

  task automatic doReset();
    rst       = 1'b1;
    enable    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    accepted = 0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_out: data=%0d first=%0b last=%0b idx=%0d, required no output",
                 out_data, out_first, out_last, frame_idx);
      end else begin
        checkOutput("out_sample", {out_data, out_first, out_last, frame_idx},
                    {expQ[0].data, expQ[0].first, expQ[0].last, expQ[0].idx});
        if (out_ready) begin
          void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset state
    doReset();
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_first", 64'(out_first), 64'd0);
    checkOutput("rst_out_last",  64'(out_last),  64'd0);
    checkOutput("rst_out_data",  64'(out_data),  64'd0);
    checkOutput("rst_frame_idx", 64'(frame_idx), 64'd0);
    checkOutput("rst_drop_cnt",  64'(drop_cnt),  64'd0);
    checkOutput("rst_in_ready",  64'(in_ready),  64'd1);

    // Basic framing: three overlapping frames from a 0..15 ramp
    @(posedge clk);
    #1;
    enable = 1'b1;
    pushFrame(0, 0);
    pushFrame(4, 1);
    pushFrame(8, 2);
    applyStimulus(0, 16);
    waitDrain(200, "basic");
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("basic_no_frame3", 64'(out_valid), 64'd0);
    checkOutput("basic_frame_idx", 64'(frame_idx), 64'd3);

    // Backpressure: out_ready toggles every cycle during frame 0
    doReset();
    enable = 1'b1;
    pushFrame(0, 0);
    fork
      applyStimulus(0, 8);
      begin
        repeat (60) begin
          @(posedge clk);
          #1;
          out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    waitDrain(100, "backpressure");
    checkOutput("bp_frame_idx", 64'(frame_idx), 64'd1);

`ifndef AUDIO_FRAME_DROP_EN
    // Full stall: writer blocks at 16, resumes once frame 0 releases HOP slots
    doReset();
    enable    = 1'b1;
    out_ready = 1'b0;
    pushFrame(0, 0);
    pushFrame(4, 1);
    pushFrame(8, 2);
    pushFrame(12, 3);
    fork
      applyStimulus(0, 20);
      begin
        int n;
        n = 0;
        while (accepted < 16 && n < 200) begin
          @(posedge clk);
          n++;
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("stall_accepted", 64'(accepted), 64'd16);
        checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain(300, "stall");
    checkOutput("stall_total",    64'(accepted),  64'd20);
    checkOutput("stall_drop_cnt", 64'(drop_cnt),  64'd0);
    checkOutput("stall_idx",      64'(frame_idx), 64'd4);
`else
    // Drop mode: no backpressure, overflow samples are counted and discarded
    doReset();
    enable    = 1'b1;
    out_ready = 1'b0;
    pushFrame(0, 0);
    pushFrame(4, 1);
    pushFrame(8, 2);
    applyStimulus(0, 20);
    @(negedge clk);
    checkOutput("drop_cnt",      64'(drop_cnt), 64'd4);
    checkOutput("drop_in_ready", 64'(in_ready), 64'd1);
    checkOutput("drop_accepted", 64'(accepted), 64'd20);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitDrain(300, "drop");
    checkOutput("drop_idx", 64'(frame_idx), 64'd3);
`endif

    // Reset in the middle of frame 1
    doReset();
    enable = 1'b1;
    pushFrame(0, 0);
    pushFrame(4, 1);
    applyStimulus(0, 12);
    waitFrameStart(1, "rstmid_f1");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    expQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkOutput("rstmid_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rstmid_frame_idx", 64'(frame_idx), 64'd0);
    checkOutput("rstmid_out_last",  64'(out_last),  64'd0);
    pushFrame(0, 0);
    @(posedge clk);
    #1;
    applyStimulus(0, 8);
    waitDrain(100, "rstmid");

    // enable dropped during frame 1: frame 1 completes, frame 2 never starts
    doReset();
    enable = 1'b1;
    pushFrame(0, 0);
    pushFrame(4, 1);
    fork
      applyStimulus(0, 20);
      begin
        waitFrameStart(1, "en_f1");
        enable = 1'b0;
      end
    join
    waitDrain(200, "enable");
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("en_no_frame2", 64'(out_valid), 64'd0);
    checkOutput("en_frame_idx", 64'(frame_idx), 64'd2);
    checkOutput("en_accepted",  64'(accepted),  64'd20);
    checkOutput("en_in_ready",  64'(in_ready),  64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
